// File: rtl/hvac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hvac_pkg : shared types for the HVAC zone scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package hvac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } mode_t;

endpackage
`default_nettype wire

// File: rtl/hvac_zone_scheduler_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_picker : first set request at or above ptr, wrapping modulo NZONES
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_picker
  import hvac_pkg::*;
#(
  parameter int NZONES = 4,
  parameter int ZW     = $clog2(NZONES)
) (
  input  logic [NZONES-1:0] req,
  input  logic [ZW-1:0]     ptr,
  output logic              valid,
  output logic [ZW-1:0]     idx
);

  logic [ZW:0] w_j;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = '0;
    for (int k = NZONES - 1; k >= 0; k--) begin
      w_j = {1'b0, ptr} + (ZW+1)'(k);
      if (w_j >= (ZW+1)'(NZONES)) begin
        w_j = w_j - (ZW+1)'(NZONES);
      end
      if (req[w_j[ZW-1:0]]) begin
        valid = 1'b1;
        idx   = w_j[ZW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hvac_zone_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hvac_zone_scheduler : round-robin sharing of one heat/cool plant by zones
// Rev 1.0
// ---------------------------------------------------------------------------
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int NZONES  = 4,
  parameter int MIN_RUN = 16,
  parameter int MAX_RUN = 64,
  parameter int DEAD    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NZONES-1:0] heat_req,
  input  logic [NZONES-1:0] cool_req,
  output logic              plant_heat,
  output logic              plant_cool,
  output logic [NZONES-1:0] zone_sel,
  output logic              busy
);

  localparam int c_ZW = $clog2(NZONES);
  localparam int c_RW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
  localparam int c_DW = $clog2(DEAD + 1);

  localparam logic [c_RW-1:0] c_RUN_SAT   = c_RW'(MAX_RUN - 1);
  localparam logic [c_RW-1:0] c_RUN_MIN   = c_RW'(MIN_RUN - 1);
  localparam logic [c_DW-1:0] c_DEAD_LAST = c_DW'(DEAD - 1);
  localparam logic [c_ZW-1:0] c_ZLAST     = c_ZW'(NZONES - 1);

  state_t            r_state;
  mode_t             r_mode;
  logic [c_ZW-1:0]   r_gz;
  logic [c_ZW-1:0]   r_ptr;
  logic [c_RW-1:0]   r_run_cnt;
  logic [c_DW-1:0]   r_dead_cnt;

  logic [NZONES-1:0] w_zreq;
  logic              w_pick_valid;
  logic [c_ZW-1:0]   w_pick_idx;
  logic [NZONES-1:0] w_gz_onehot;
  logic              w_own_req;
  logic              w_other_req;
  logic              w_release;
  logic [c_ZW-1:0]   w_ptr_next;

  assign w_zreq      = heat_req | cool_req;
  assign w_gz_onehot = {{(NZONES-1){1'b0}}, 1'b1} << r_gz;
  assign w_own_req   = (r_mode == MODE_HEAT) ? heat_req[r_gz] : cool_req[r_gz];
  assign w_other_req = |(w_zreq & ~w_gz_onehot);
  assign w_ptr_next  = (r_gz == c_ZLAST) ? '0 : r_gz + 1'b1;

  // Minimum run satisfied and own request gone, or quantum spent under contention.
  assign w_release = ((r_run_cnt >= c_RUN_MIN) && !w_own_req) ||
                     ((r_run_cnt == c_RUN_SAT) && w_other_req);

  rr_picker #(
    .NZONES (NZONES),
    .ZW     (c_ZW)
  ) u_picker (
    .req   (w_zreq),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // Outputs are a registered image of the current state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= hvac_pkg::IDLE;
      r_mode     <= MODE_HEAT;
      r_gz       <= '0;
      r_ptr      <= '0;
      r_run_cnt  <= '0;
      r_dead_cnt <= '0;
      plant_heat <= 1'b0;
      plant_cool <= 1'b0;
      zone_sel   <= '0;
      busy       <= 1'b0;
    end else begin
      plant_heat <= (r_state == hvac_pkg::RUN) && (r_mode == MODE_HEAT);
      plant_cool <= (r_state == hvac_pkg::RUN) && (r_mode == MODE_COOL);
      zone_sel   <= (r_state == hvac_pkg::RUN) ? w_gz_onehot : '0;
      busy       <= (r_state != hvac_pkg::IDLE);

      case (r_state)
        hvac_pkg::IDLE: begin
          if (w_pick_valid) begin
            r_gz      <= w_pick_idx;
            r_mode    <= heat_req[w_pick_idx] ? MODE_HEAT : MODE_COOL;
            r_run_cnt <= '0;
            r_state   <= hvac_pkg::RUN;
          end
        end
        hvac_pkg::RUN: begin
          if (w_release) begin
            r_state    <= hvac_pkg::DEAD;
            r_dead_cnt <= '0;
            r_ptr      <= w_ptr_next;
          end else if (r_run_cnt != c_RUN_SAT) begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end
        hvac_pkg::DEAD: begin
          if (r_dead_cnt == c_DEAD_LAST) begin
            r_state <= hvac_pkg::IDLE;
          end else begin
            r_dead_cnt <= r_dead_cnt + 1'b1;
          end
        end
        default: r_state <= hvac_pkg::IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hvac_zone_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hvac_zone_scheduler : directed scenarios plus random requests vs. model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hvac_zone_scheduler;

  localparam int N       = 4;
  localparam int MIN_RUN = 16;
  localparam int MAX_RUN = 64;
  localparam int DEAD_T  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] heat_req = '0;
  logic [N-1:0] cool_req = '0;
  logic         plant_heat;
  logic         plant_cool;
  logic [N-1:0] zone_sel;
  logic         busy;

  hvac_zone_scheduler #(
    .NZONES  (N),
    .MIN_RUN (MIN_RUN),
    .MAX_RUN (MAX_RUN),
    .DEAD    (DEAD_T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .heat_req   (heat_req),
    .cool_req   (cool_req),
    .plant_heat (plant_heat),
    .plant_cool (plant_cool),
    .zone_sel   (zone_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plant owner (-1 = nobody), cycles it has held the plant,
  // remaining cool-down cycles, and the zone that gets first look next time.
  int m_zone      = -1;
  int m_heat      = 0;
  int m_on        = 0;
  int m_cool_left = 0;
  int m_ptr       = 0;

  int g_zone[$];
  int g_start[$];
  int g_len[$];
  int g_heat[$];
  int cyc         = 0;
  int busy_off    = 0;
  int heat_cycles = 0;
  logic [N-1:0] prev_sel = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_advance();
    logic [N-1:0] zr;
    logic [N-1:0] mine;
    zr = heat_req | cool_req;
    if (m_zone >= 0) begin
      bit own;
      bit others;
      m_on++;
      mine = '0;
      mine[m_zone] = 1'b1;
      own    = (m_heat != 0) ? heat_req[m_zone] : cool_req[m_zone];
      others = ((zr & ~mine) != '0);
      if ((m_on >= MIN_RUN && !own) || (m_on >= MAX_RUN && others)) begin
        m_ptr       = (m_zone + 1) % N;
        m_zone      = -1;
        m_cool_left = DEAD_T;
      end
    end else if (m_cool_left > 0) begin
      m_cool_left--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int z;
        z = (m_ptr + k) % N;
        if (zr[z]) begin
          m_zone = z;
          m_heat = heat_req[z] ? 1 : 0;
          m_on   = 0;
          break;
        end
      end
    end
  endtask

  task automatic step();
    int e_heat;
    int e_cool;
    int e_sel;
    int e_busy;
    @(posedge clk);
    if (m_zone >= 0) begin
      e_heat = m_heat;
      e_cool = 1 - m_heat;
      e_sel  = 1 << m_zone;
      e_busy = 1;
    end else begin
      e_heat = 0;
      e_cool = 0;
      e_sel  = 0;
      e_busy = (m_cool_left > 0) ? 1 : 0;
    end
    if (!rst_n) begin
      m_zone = -1; m_on = 0; m_cool_left = 0; m_ptr = 0; m_heat = 0;
      e_heat = 0; e_cool = 0; e_sel = 0; e_busy = 0;
    end else begin
      model_advance();
    end
    #1;
    cyc++;
    chk("plant_heat", plant_heat, e_heat);
    chk("plant_cool", plant_cool, e_cool);
    chk("zone_sel", zone_sel, e_sel);
    chk("busy", busy, e_busy);
    chk("heat_and_cool", plant_heat & plant_cool, 0);
    chk("sel_onehot", ($countones(zone_sel) <= 1), 1);
    if (prev_sel == '0 && zone_sel != '0) begin
      g_start.push_back(cyc);
      g_zone.push_back($clog2(zone_sel));
      g_heat.push_back(plant_heat);
    end
    if (prev_sel != '0 && zone_sel == '0) g_len.push_back(cyc - g_start[$]);
    if (busy && zone_sel == '0) busy_off++;
    if (plant_heat) heat_cycles++;
    prev_sel = zone_sel;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    heat_req = '0;
    cool_req = '0;
    step();
    step();
    rst_n = 1'b1;
    g_zone.delete(); g_start.delete(); g_len.delete(); g_heat.delete();
    busy_off = 0;
    heat_cycles = 0;
  endtask

  initial begin
    int exp_z[4];
    exp_z = '{0, 1, 3, 0};

    // Reset and idle
    do_reset();
    repeat (20) step();
    chk("idle_busy", busy, 0);
    chk("idle_sel", zone_sel, 0);

    // Single heat pulse on zone 2: minimum run then dead time
    do_reset();
    heat_req = 4'b0100;
    step();
    heat_req = '0;
    repeat (40) step();
    chk("s2_ngrants", g_zone.size(), 1);
    if (g_zone.size() == 1 && g_len.size() == 1) begin
      chk("s2_zone", g_zone[0], 2);
      chk("s2_len", g_len[0], MIN_RUN);
      chk("s2_heat", g_heat[0], 1);
    end
    chk("s2_dead", busy_off, DEAD_T);
    chk("s2_idle", busy, 0);

    // Contended cooling: quantum-limited round robin
    do_reset();
    cool_req = 4'b1011;
    repeat (300) step();
    chk("s3_ngrants", (g_zone.size() >= 4 && g_len.size() >= 3), 1);
    if (g_zone.size() >= 4 && g_len.size() >= 3) begin
      for (int i = 0; i < 4; i++) chk($sformatf("s3_zone%0d", i), g_zone[i], exp_z[i]);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("s3_len%0d", i), g_len[i], MAX_RUN);
        chk($sformatf("s3_gap%0d", i), g_start[i+1] - (g_start[i] + g_len[i]), DEAD_T + 1);
      end
    end
    chk("s3_noheat", heat_cycles, 0);

    // Zone 2 switches from heat to cool after 30 cycles
    do_reset();
    heat_req = 4'b0100;
    repeat (30) step();
    heat_req = '0;
    cool_req = 4'b0100;
    repeat (40) step();
    chk("s4_ngrants", (g_zone.size() >= 2 && g_len.size() >= 1), 1);
    if (g_zone.size() >= 2 && g_len.size() >= 1) begin
      chk("s4_heat_len", g_len[0], 30);
      chk("s4_first_heat", g_heat[0], 1);
      chk("s4_second_zone", g_zone[1], 2);
      chk("s4_second_heat", g_heat[1], 0);
      chk("s4_gap", g_start[1] - (g_start[0] + g_len[0]), DEAD_T + 1);
    end
    chk("s4_cool_on", plant_cool, 1);
    chk("s4_cool_sel", zone_sel, 4'b0100);

    // Heat and cool together in zone 1: heat wins
    do_reset();
    heat_req = 4'b0010;
    cool_req = 4'b0010;
    step();
    step();
    chk("s5_heat", plant_heat, 1);
    chk("s5_cool", plant_cool, 0);
    chk("s5_sel", zone_sel, 4'b0010);
    heat_req = '0;
    cool_req = '0;
    repeat (25) step();

    // Reset mid-run clears outputs and the round-robin pointer
    do_reset();
    heat_req = 4'b0010;
    repeat (21) step();
    heat_req = '0;
    repeat (10) step();
    heat_req = 4'b0100;
    repeat (6) step();
    chk("s6_running", zone_sel, 4'b0100);
    rst_n = 1'b0;
    heat_req = 4'b1001;
    step();
    chk("s6_rst_heat", plant_heat, 0);
    chk("s6_rst_sel", zone_sel, 0);
    chk("s6_rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("s6_latency", zone_sel, 0);
    step();
    chk("s6_ptr0", zone_sel, 4'b0001);
    rst_n = 1'b0;
    heat_req = 4'b1000;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("s6_zone3", zone_sel, 4'b1000);
    chk("s6_zone3_heat", plant_heat, 1);

    // Random slowly-varying requests with rare resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 39) == 0) heat_req[b] = ~heat_req[b];
        if ($urandom_range(0, 39) == 0) cool_req[b] = ~cool_req[b];
      end
      rst_n = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
